// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave frame sequencer.
// Frames are 8 or 16 bits wide, and the R/Wn flag is the MSB of the command frame.
package spi_pkg;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StHold} state_e;

  localparam logic [3:0] LEN_8B  = 4'd7;
  localparam logic [3:0] LEN_16B = 4'd15;

  // R/Wn sits at the frame MSB, so its position follows LEN.
  function automatic logic [3:0] cmd_rw_bit(input logic [3:0] len);
    return len;
  endfunction

  function automatic logic len_legal(input logic [3:0] len);
    return (len == LEN_8B) || (len == LEN_16B);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Per-frame bit counter. It flags the last bit of a frame and produces the
// MISO bit index for the TX word.
module spi_bit_counter (
  input  logic       sclk_sample,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       cnt_en_i,
  input  logic [3:0] len_i,
  output logic [4:0] bit_cnt_o,
  output logic       frame_end_o,
  output logic [3:0] tx_idx_o
);

  logic [4:0] cnt_q;

  assign bit_cnt_o   = cnt_q;
  assign frame_end_o = cnt_en_i && (cnt_q == {1'b0, len_i});
  // Modulo-16 subtraction is intentional.
  assign tx_idx_o    = len_i - cnt_q[3:0];

  always_ff @(posedge sclk_sample or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || frame_end_o) begin
      cnt_q <= '0;
    end else if (cnt_en_i) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/spi_slave_frame_seq.sv
// SPI slave frame sequencer. It decodes a command frame, then runs the data frames
// and emits toggle-coded cmd/write/read-prefetch events toward the system clock domain.
module spi_slave_frame_seq #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 7,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          sclk_sample,
  input  logic          rst,
  input  logic          i_CSn,
  input  logic          i_MOSI,
  input  logic [3:0]    LEN,
  input  logic          i_auto_inc,
  output logic [DW-1:0] o_rx_word,
  output logic [3:0]    o_tx_idx,
  output logic [AW-1:0] o_addr,
  output logic          o_rw,
  output logic          o_cmd_tgl,
  output logic          o_wr_tgl,
  output logic          o_rd_tgl,
  output logic          o_err_len,
  output logic          o_burst_ovf
);
  import spi_pkg::*;

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  state_e        state_q;
  logic [DW-1:0] shift_q;
  logic [BW-1:0] burst_q;
  logic          inc_pend_q;

  logic [4:0]    bit_cnt;
  logic          frame_end;
  logic          len_ok;
  logic          frame_start;
  logic          start_block;
  logic          shift_en;
  logic [DW-1:0] len_mask;
  logic [DW-1:0] frame_word;

  always_comb begin
    len_ok      = len_legal(LEN);
    frame_start = !i_CSn && ((state_q == StIdle) ||
                             ((state_q == StData) && (bit_cnt == 5'd0)));
    start_block = frame_start &&
                  (!len_ok || ((state_q == StData) && (burst_q == BW'(MAX_BURST))));
    shift_en    = !i_CSn && (state_q != StHold) && !start_block;
    len_mask    = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      len_mask[i] = (i <= 32'(LEN));
    end
    frame_word  = {shift_q[DW-2:0], i_MOSI} & len_mask;
  end

  spi_bit_counter u_bit_counter (
    .sclk_sample (sclk_sample),
    .rst         (rst),
    .clr_i       (i_CSn),
    .cnt_en_i    (shift_en),
    .len_i       (LEN),
    .bit_cnt_o   (bit_cnt),
    .frame_end_o (frame_end),
    .tx_idx_o    (o_tx_idx)
  );

  always_ff @(posedge sclk_sample or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      burst_q     <= '0;
      inc_pend_q  <= 1'b0;
      o_rx_word   <= '0;
      o_addr      <= '0;
      o_rw        <= 1'b0;
      o_cmd_tgl   <= 1'b0;
      o_wr_tgl    <= 1'b0;
      o_rd_tgl    <= 1'b0;
      o_err_len   <= 1'b0;
      o_burst_ovf <= 1'b0;
    end else begin
      // The target address is held through the event edge, and the increment lands one edge later.
      inc_pend_q <= 1'b0;
      if (inc_pend_q) begin
        o_addr <= o_addr + AW'(1);
      end
      if (shift_en) begin
        shift_q <= {shift_q[DW-2:0], i_MOSI};
      end
      if (i_CSn) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!len_ok) begin
              o_err_len <= 1'b1;
              state_q   <= StHold;
            end else begin
              state_q <= StCmd;
            end
          end
          StCmd: begin
            if (frame_end) begin
              o_rx_word <= frame_word;
              o_rw      <= frame_word[cmd_rw_bit(LEN)];
              o_addr    <= frame_word[AW-1:0];
              o_cmd_tgl <= ~o_cmd_tgl;
              if (frame_word[cmd_rw_bit(LEN)]) begin
                o_rd_tgl <= ~o_rd_tgl;
              end
              burst_q <= '0;
              state_q <= StData;
            end
          end
          StData: begin
            if (start_block) begin
              if (!len_ok) begin
                o_err_len <= 1'b1;
              end else begin
                o_burst_ovf <= 1'b1;
              end
              state_q <= StHold;
            end else if (frame_end) begin
              o_rx_word <= frame_word;
              if (o_rw) begin
                o_rd_tgl <= ~o_rd_tgl;
              end else begin
                o_wr_tgl <= ~o_wr_tgl;
              end
              burst_q    <= burst_q + BW'(1);
              inc_pend_q <= i_auto_inc;
            end
          end
          StHold: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_frame_seq.sv
// Directed bench for spi_slave_frame_seq. Inputs are driven on the falling edge,
// and outputs are sampled 1 ns after the rising edge.
module tb_spi_slave_frame_seq;

  logic        sclk_sample = 1'b0;
  logic        rst = 1'b1;
  logic        i_CSn = 1'b1;
  logic        i_MOSI = 1'b0;
  logic [3:0]  LEN = 4'd7;
  logic        i_auto_inc = 1'b0;
  logic [15:0] o_rx_word;
  logic [3:0]  o_tx_idx;
  logic [6:0]  o_addr;
  logic        o_rw, o_cmd_tgl, o_wr_tgl, o_rd_tgl, o_err_len, o_burst_ovf;

  int errors = 0;
  int checks = 0;
  logic exp_cmd, exp_wr, exp_rd;

  always #5 sclk_sample = ~sclk_sample;

  spi_slave_frame_seq #(.DW(16), .AW(7), .MAX_BURST(8)) dut (
    .sclk_sample (sclk_sample),
    .rst         (rst),
    .i_CSn       (i_CSn),
    .i_MOSI      (i_MOSI),
    .LEN         (LEN),
    .i_auto_inc  (i_auto_inc),
    .o_rx_word   (o_rx_word),
    .o_tx_idx    (o_tx_idx),
    .o_addr      (o_addr),
    .o_rw        (o_rw),
    .o_cmd_tgl   (o_cmd_tgl),
    .o_wr_tgl    (o_wr_tgl),
    .o_rd_tgl    (o_rd_tgl),
    .o_err_len   (o_err_len),
    .o_burst_ovf (o_burst_ovf)
  );

  task automatic clk_bit(input logic csn, input logic mosi);
    @(negedge sclk_sample);
    i_CSn  = csn;
    i_MOSI = mosi;
    @(posedge sclk_sample);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) clk_bit(1'b0, w[i]);
  endtask

  task automatic test_reset;
    @(negedge sclk_sample);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_cmd = 1'b0; exp_wr = 1'b0; exp_rd = 1'b0;
    #1;
    checks++;
    if (o_rx_word !== 16'h0 || o_addr !== 7'h0 || o_rw !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rx=%h addr=%h rw=%b want 0 0 0", o_rx_word, o_addr, o_rw);
    end
    checks++;
    if ({o_cmd_tgl, o_wr_tgl, o_rd_tgl, o_err_len, o_burst_ovf} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {o_cmd_tgl, o_wr_tgl, o_rd_tgl, o_err_len, o_burst_ovf});
    end
    checks++;
    if (o_tx_idx !== 4'd7) begin
      errors++;
      $display("FAIL reset_tx_idx: got %0d want 7", o_tx_idx);
    end
  endtask

  task automatic test_write_auto_inc;
    LEN = 4'd7; i_auto_inc = 1'b1;
    send_frame(16'h0005, 8);
    exp_cmd = ~exp_cmd;
    checks++;
    if (o_cmd_tgl !== exp_cmd || o_wr_tgl !== exp_wr || o_rd_tgl !== exp_rd ||
        o_rw !== 1'b0 || o_addr !== 7'h05) begin
      errors++;
      $display("FAIL wr_cmd: cmd=%b wr=%b rd=%b rw=%b addr=%h want %b %b %b 0 05",
               o_cmd_tgl, o_wr_tgl, o_rd_tgl, o_rw, o_addr, exp_cmd, exp_wr, exp_rd);
    end
    send_frame(16'h00A5, 8);
    exp_wr = ~exp_wr;
    checks++;
    if (o_wr_tgl !== exp_wr || o_addr !== 7'h05 || o_rx_word !== 16'h00A5) begin
      errors++;
      $display("FAIL wr_data0: wr=%b addr=%h rx=%h want %b 05 00a5",
               o_wr_tgl, o_addr, o_rx_word, exp_wr);
    end
    send_frame(16'h003C, 8);
    exp_wr = ~exp_wr;
    checks++;
    if (o_wr_tgl !== exp_wr || o_addr !== 7'h06 || o_rx_word !== 16'h003C) begin
      errors++;
      $display("FAIL wr_data1: wr=%b addr=%h rx=%h want %b 06 003c",
               o_wr_tgl, o_addr, o_rx_word, exp_wr);
    end
    clk_bit(1'b1, 1'b0);
    checks++;
    if (o_addr !== 7'h07 || o_cmd_tgl !== exp_cmd) begin
      errors++;
      $display("FAIL wr_after: addr=%h cmd=%b want 07 %b", o_addr, o_cmd_tgl, exp_cmd);
    end
  endtask

  task automatic test_read_wrap;
    logic [15:0] d;
    int idx_bad;
    LEN = 4'd15; i_auto_inc = 1'b1;
    clk_bit(1'b1, 1'b0);
    send_frame(16'h807F, 16);
    exp_cmd = ~exp_cmd; exp_rd = ~exp_rd;
    checks++;
    if (o_cmd_tgl !== exp_cmd || o_rd_tgl !== exp_rd || o_rw !== 1'b1 || o_addr !== 7'h7F) begin
      errors++;
      $display("FAIL rd_cmd: cmd=%b rd=%b rw=%b addr=%h want %b %b 1 7f",
               o_cmd_tgl, o_rd_tgl, o_rw, o_addr, exp_cmd, exp_rd);
    end
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 16'h1234 : 16'hBEEF;
      idx_bad = 0;
      for (int j = 0; j < 16; j++) begin
        if (o_tx_idx !== 4'(15 - j)) idx_bad++;
        clk_bit(1'b0, d[15-j]);
        if (j == 0) begin
          checks++;
          if (o_addr !== 7'(f == 0 ? 7'h7F : 7'h00)) begin
            errors++;
            $display("FAIL rd_addr_frame%0d_bit0: got %h", f, o_addr);
          end
        end
      end
      exp_rd = ~exp_rd;
      checks++;
      if (idx_bad != 0) begin
        errors++;
        $display("FAIL rd_tx_idx_frame%0d: %0d wrong of 16 want 15..0", f, idx_bad);
      end
      checks++;
      if (o_rd_tgl !== exp_rd || o_rx_word !== d) begin
        errors++;
        $display("FAIL rd_data%0d: rd=%b rx=%h want %b %h", f, o_rd_tgl, o_rx_word, exp_rd, d);
      end
    end
    clk_bit(1'b1, 1'b0);
    checks++;
    if (o_addr !== 7'h01 || o_tx_idx !== 4'd15 || o_wr_tgl !== exp_wr) begin
      errors++;
      $display("FAIL rd_wrap: addr=%h idx=%0d wr=%b want 01 15 %b",
               o_addr, o_tx_idx, o_wr_tgl, exp_wr);
    end
  endtask

  task automatic test_abort;
    LEN = 4'd7; i_auto_inc = 1'b0;
    send_frame(16'h0012, 8);
    exp_cmd = ~exp_cmd;
    send_frame(16'h000B, 4);
    checks++;
    if (o_tx_idx !== 4'd3) begin
      errors++;
      $display("FAIL abort_mid_idx: got %0d want 3", o_tx_idx);
    end
    clk_bit(1'b1, 1'b1);
    checks++;
    if (o_wr_tgl !== exp_wr || o_tx_idx !== 4'd7 || o_addr !== 7'h12 ||
        o_rx_word !== 16'h0012 || o_cmd_tgl !== exp_cmd) begin
      errors++;
      $display("FAIL abort: wr=%b idx=%0d addr=%h rx=%h cmd=%b want %b 7 12 0012 %b",
               o_wr_tgl, o_tx_idx, o_addr, o_rx_word, o_cmd_tgl, exp_wr, exp_cmd);
    end
    send_frame(16'h0083, 8);
    exp_cmd = ~exp_cmd; exp_rd = ~exp_rd;
    checks++;
    if (o_cmd_tgl !== exp_cmd || o_rd_tgl !== exp_rd || o_rw !== 1'b1 || o_addr !== 7'h03) begin
      errors++;
      $display("FAIL abort_newcmd: cmd=%b rd=%b rw=%b addr=%h want %b %b 1 03",
               o_cmd_tgl, o_rd_tgl, o_rw, o_addr, exp_cmd, exp_rd);
    end
    clk_bit(1'b1, 1'b0);
  endtask

  task automatic test_err_len;
    LEN = 4'd9;
    clk_bit(1'b0, 1'b1);
    checks++;
    if (o_err_len !== 1'b1 || o_tx_idx !== 4'd9) begin
      errors++;
      $display("FAIL err_len_set: err=%b idx=%0d want 1 9", o_err_len, o_tx_idx);
    end
    send_frame(16'hFFFF, 16);
    checks++;
    if (o_cmd_tgl !== exp_cmd || o_wr_tgl !== exp_wr || o_rd_tgl !== exp_rd ||
        o_rx_word !== 16'h0083 || o_tx_idx !== 4'd9) begin
      errors++;
      $display("FAIL err_len_hold: cmd=%b wr=%b rd=%b rx=%h idx=%0d want %b %b %b 0083 9",
               o_cmd_tgl, o_wr_tgl, o_rd_tgl, o_rx_word, o_tx_idx, exp_cmd, exp_wr, exp_rd);
    end
    clk_bit(1'b1, 1'b0);
    LEN = 4'd7;
    send_frame(16'h0001, 8);
    send_frame(16'h0055, 8);
    exp_cmd = ~exp_cmd; exp_wr = ~exp_wr;
    checks++;
    if (o_cmd_tgl !== exp_cmd || o_wr_tgl !== exp_wr || o_rx_word !== 16'h0055 ||
        o_addr !== 7'h01 || o_err_len !== 1'b1) begin
      errors++;
      $display("FAIL err_len_sticky: cmd=%b wr=%b rx=%h addr=%h err=%b want %b %b 0055 01 1",
               o_cmd_tgl, o_wr_tgl, o_rx_word, o_addr, o_err_len, exp_cmd, exp_wr);
    end
    clk_bit(1'b1, 1'b0);
  endtask

  task automatic test_burst_ovf;
    int bad;
    LEN = 4'd7; i_auto_inc = 1'b1;
    send_frame(16'h0010, 8);
    exp_cmd = ~exp_cmd;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      send_frame(16'(8'h40 + k), 8);
      exp_wr = ~exp_wr;
      if (o_wr_tgl !== exp_wr || o_addr !== 7'(7'h10 + k) || o_rx_word !== 16'(8'h40 + k)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL burst_frames: %0d of 8 frames wrong", bad);
    end
    checks++;
    if (o_burst_ovf !== 1'b0) begin
      errors++;
      $display("FAIL burst_no_ovf_at_max: got %b want 0", o_burst_ovf);
    end
    clk_bit(1'b0, 1'b1);
    checks++;
    if (o_burst_ovf !== 1'b1 || o_addr !== 7'h18) begin
      errors++;
      $display("FAIL burst_ovf_set: ovf=%b addr=%h want 1 18", o_burst_ovf, o_addr);
    end
    send_frame(16'h00FF, 7);
    checks++;
    if (o_wr_tgl !== exp_wr || o_rx_word !== 16'h0047 || o_tx_idx !== 4'd7) begin
      errors++;
      $display("FAIL burst_hold: wr=%b rx=%h idx=%0d want %b 0047 7",
               o_wr_tgl, o_rx_word, o_tx_idx, exp_wr);
    end
    send_frame(16'h0003, 3);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_rx_word !== 16'h0 || o_addr !== 7'h0 || o_rw !== 1'b0 || o_tx_idx !== 4'd7 ||
        {o_cmd_tgl, o_wr_tgl, o_rd_tgl, o_err_len, o_burst_ovf} !== 5'b0) begin
      errors++;
      $display("FAIL burst_rst: rx=%h addr=%h rw=%b idx=%0d flags=%b want 0 0 0 7 00000",
               o_rx_word, o_addr, o_rw, o_tx_idx,
               {o_cmd_tgl, o_wr_tgl, o_rd_tgl, o_err_len, o_burst_ovf});
    end
    @(negedge sclk_sample);
    i_CSn = 1'b1;
    rst = 1'b0;
  endtask

  initial begin
    exp_cmd = 1'b0; exp_wr = 1'b0; exp_rd = 1'b0;
    test_reset();
    test_write_auto_inc();
    test_read_wrap();
    test_abort();
    test_err_len();
    test_burst_ovf();
    repeat (2) @(posedge sclk_sample);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
